// File: rtl/peregrine_inbound_pif_arbiter.sv
// rtl/peregrine_inbound_pif_arbiter.sv - two-master round-robin arbiter for the peregrine inbound PIF slave port
// Optional feature macro: PEREGRINE_PIFARB_PRIORITY_EN (priority-first tie break in IDLE).
module peregrine_inbound_pif_arbiter #(
   parameter int ID_W   = 6,
   parameter int DATA_W = 32
) (
   input  logic                CLK,
   input  logic                RESETN,
   input  logic                PIReqValid_M0,
   output logic                POReqRdy_M0,
   input  logic [7:0]          PIReqCntl_M0,
   input  logic [31:0]         PIReqAdrs_M0,
   input  logic [DATA_W-1:0]   PIReqData_M0,
   input  logic [DATA_W/8-1:0] PIReqDataBE_M0,
   input  logic [ID_W-1:0]     PIReqId_M0,
   input  logic [1:0]          PIReqPriority_M0,
   output logic                PORespValid_M0,
   input  logic                PIRespRdy_M0,
   output logic [7:0]          PORespCntl_M0,
   output logic [DATA_W-1:0]   PORespData_M0,
   output logic [ID_W-1:0]     PORespId_M0,
   output logic [1:0]          PORespPriority_M0,
   input  logic                PIReqValid_M1,
   output logic                POReqRdy_M1,
   input  logic [7:0]          PIReqCntl_M1,
   input  logic [31:0]         PIReqAdrs_M1,
   input  logic [DATA_W-1:0]   PIReqData_M1,
   input  logic [DATA_W/8-1:0] PIReqDataBE_M1,
   input  logic [ID_W-1:0]     PIReqId_M1,
   input  logic [1:0]          PIReqPriority_M1,
   output logic                PORespValid_M1,
   input  logic                PIRespRdy_M1,
   output logic [7:0]          PORespCntl_M1,
   output logic [DATA_W-1:0]   PORespData_M1,
   output logic [ID_W-1:0]     PORespId_M1,
   output logic [1:0]          PORespPriority_M1,
   output logic                PIReqValid_S,
   output logic [7:0]          PIReqCntl_S,
   output logic [31:0]         PIReqAdrs_S,
   output logic [DATA_W-1:0]   PIReqData_S,
   output logic [DATA_W/8-1:0] PIReqDataBE_S,
   output logic [ID_W-1:0]     PIReqId_S,
   output logic [1:0]          PIReqPriority_S,
   input  logic                POReqRdy_S,
   input  logic                PORespValid_S,
   input  logic [7:0]          PORespCntl_S,
   input  logic [DATA_W-1:0]   PORespData_S,
   input  logic [ID_W-1:0]     PORespId_S,
   input  logic [1:0]          PORespPriority_S,
   output logic                PIRespRdy_S
);

   localparam int NID = 2**ID_W;

   typedef enum logic {ST_IDLE, ST_LOCK} state_t;

   state_t         state_q, state_d;
   logic           owner_q, owner_d;
   logic           rr_last_q, rr_last_d;
   logic [NID-1:0] own_valid_q, own_valid_d;
   logic [NID-1:0] own_mst_q, own_mst_d;

   logic blocked_m0, blocked_m1, elig_m0, elig_m1;
   logic both_pick, gnt_valid, gnt_sel;
   logic req_acc, req_last, resp_acc, resp_dst;

   // ID collisions only gate new arbitration; a locked burst keeps its grant.
   assign blocked_m0 = (state_q == ST_IDLE) && own_valid_q[PIReqId_M0];
   assign blocked_m1 = (state_q == ST_IDLE) && own_valid_q[PIReqId_M1];
   assign elig_m0    = PIReqValid_M0 && !blocked_m0;
   assign elig_m1    = PIReqValid_M1 && !blocked_m1;

   always_comb begin
      both_pick = ~rr_last_q;
`ifdef PEREGRINE_PIFARB_PRIORITY_EN
      if (PIReqPriority_M0 > PIReqPriority_M1) begin
         both_pick = 1'b0;
      end else if (PIReqPriority_M1 > PIReqPriority_M0) begin
         both_pick = 1'b1;
      end
`endif
   end

   always_comb begin
      gnt_valid = 1'b0;
      gnt_sel   = 1'b0;
      if (state_q == ST_LOCK) begin
         gnt_valid = 1'b1;
         gnt_sel   = owner_q;
      end else if (elig_m0 && elig_m1) begin
         gnt_valid = 1'b1;
         gnt_sel   = both_pick;
      end else if (elig_m0) begin
         gnt_valid = 1'b1;
         gnt_sel   = 1'b0;
      end else if (elig_m1) begin
         gnt_valid = 1'b1;
         gnt_sel   = 1'b1;
      end
   end

   // Handshake outputs are forced low while reset is asserted, independent of the inputs.
   assign PIReqValid_S    = RESETN && gnt_valid && (gnt_sel ? PIReqValid_M1 : PIReqValid_M0);
   assign PIReqCntl_S     = gnt_sel ? PIReqCntl_M1     : PIReqCntl_M0;
   assign PIReqAdrs_S     = gnt_sel ? PIReqAdrs_M1     : PIReqAdrs_M0;
   assign PIReqData_S     = gnt_sel ? PIReqData_M1     : PIReqData_M0;
   assign PIReqDataBE_S   = gnt_sel ? PIReqDataBE_M1   : PIReqDataBE_M0;
   assign PIReqId_S       = gnt_sel ? PIReqId_M1       : PIReqId_M0;
   assign PIReqPriority_S = gnt_sel ? PIReqPriority_M1 : PIReqPriority_M0;
   assign POReqRdy_M0     = RESETN && POReqRdy_S && gnt_valid && !gnt_sel;
   assign POReqRdy_M1     = RESETN && POReqRdy_S && gnt_valid && gnt_sel;

   assign req_acc  = PIReqValid_S && POReqRdy_S;
   assign req_last = PIReqCntl_S[0];

   // Unowned IDs fall through to M0 so a stray response still drains.
   assign resp_dst       = own_valid_q[PORespId_S] && own_mst_q[PORespId_S];
   assign PORespValid_M0 = RESETN && PORespValid_S && !resp_dst;
   assign PORespValid_M1 = RESETN && PORespValid_S && resp_dst;
   assign PIRespRdy_S    = RESETN && (resp_dst ? PIRespRdy_M1 : PIRespRdy_M0);
   assign resp_acc       = PORespValid_S && PIRespRdy_S;

   assign PORespCntl_M0     = PORespCntl_S;
   assign PORespData_M0     = PORespData_S;
   assign PORespId_M0       = PORespId_S;
   assign PORespPriority_M0 = PORespPriority_S;
   assign PORespCntl_M1     = PORespCntl_S;
   assign PORespData_M1     = PORespData_S;
   assign PORespId_M1       = PORespId_S;
   assign PORespPriority_M1 = PORespPriority_S;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_last_d   = rr_last_q;
      own_valid_d = own_valid_q;
      own_mst_d   = own_mst_q;
      case (state_q)
         ST_IDLE: begin
            if (req_acc) begin
               if (req_last) begin
                  rr_last_d = gnt_sel;
               end else begin
                  state_d = ST_LOCK;
                  owner_d = gnt_sel;
               end
            end
         end
         ST_LOCK: begin
            if (req_acc && req_last) begin
               state_d   = ST_IDLE;
               rr_last_d = owner_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Clear before set so a same-cycle reuse of an ID stays owned.
      if (resp_acc && PORespCntl_S[0]) begin
         own_valid_d[PORespId_S] = 1'b0;
      end
      if (req_acc && req_last) begin
         own_valid_d[PIReqId_S] = 1'b1;
         own_mst_d[PIReqId_S]   = gnt_sel;
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q     <= ST_IDLE;
         owner_q     <= 1'b0;
         rr_last_q   <= 1'b1;
         own_valid_q <= '0;
         own_mst_q   <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_last_q   <= rr_last_d;
         own_valid_q <= own_valid_d;
         own_mst_q   <= own_mst_d;
      end
   end

   resp_owned_a: assert property (@(posedge CLK) disable iff (!RESETN)
      PORespValid_S |-> own_valid_q[PORespId_S]);

endmodule

// File: tb/tb_peregrine_inbound_pif_arbiter.sv
// tb/tb_peregrine_inbound_pif_arbiter.sv - directed self-checking bench for peregrine_inbound_pif_arbiter
// Honours PEREGRINE_PIFARB_PRIORITY_EN when computing arbitration expectations.
module tb_peregrine_inbound_pif_arbiter;
   localparam int ID_W = 6;
   localparam int DATA_W = 32;

   logic CLK = 1'b0;
   logic RESETN;
   logic PIReqValid_M0, POReqRdy_M0, PORespValid_M0, PIRespRdy_M0;
   logic [7:0] PIReqCntl_M0, PORespCntl_M0;
   logic [31:0] PIReqAdrs_M0;
   logic [DATA_W-1:0] PIReqData_M0, PORespData_M0;
   logic [DATA_W/8-1:0] PIReqDataBE_M0;
   logic [ID_W-1:0] PIReqId_M0, PORespId_M0;
   logic [1:0] PIReqPriority_M0, PORespPriority_M0;
   logic PIReqValid_M1, POReqRdy_M1, PORespValid_M1, PIRespRdy_M1;
   logic [7:0] PIReqCntl_M1, PORespCntl_M1;
   logic [31:0] PIReqAdrs_M1;
   logic [DATA_W-1:0] PIReqData_M1, PORespData_M1;
   logic [DATA_W/8-1:0] PIReqDataBE_M1;
   logic [ID_W-1:0] PIReqId_M1, PORespId_M1;
   logic [1:0] PIReqPriority_M1, PORespPriority_M1;
   logic PIReqValid_S, POReqRdy_S, PORespValid_S, PIRespRdy_S;
   logic [7:0] PIReqCntl_S, PORespCntl_S;
   logic [31:0] PIReqAdrs_S;
   logic [DATA_W-1:0] PIReqData_S, PORespData_S;
   logic [DATA_W/8-1:0] PIReqDataBE_S;
   logic [ID_W-1:0] PIReqId_S, PORespId_S;
   logic [1:0] PIReqPriority_S, PORespPriority_S;

   int vectors = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   peregrine_inbound_pif_arbiter #(.ID_W(ID_W), .DATA_W(DATA_W)) dut (
      .CLK(CLK), .RESETN(RESETN),
      .PIReqValid_M0(PIReqValid_M0), .POReqRdy_M0(POReqRdy_M0), .PIReqCntl_M0(PIReqCntl_M0),
      .PIReqAdrs_M0(PIReqAdrs_M0), .PIReqData_M0(PIReqData_M0), .PIReqDataBE_M0(PIReqDataBE_M0),
      .PIReqId_M0(PIReqId_M0), .PIReqPriority_M0(PIReqPriority_M0), .PORespValid_M0(PORespValid_M0),
      .PIRespRdy_M0(PIRespRdy_M0), .PORespCntl_M0(PORespCntl_M0), .PORespData_M0(PORespData_M0),
      .PORespId_M0(PORespId_M0), .PORespPriority_M0(PORespPriority_M0),
      .PIReqValid_M1(PIReqValid_M1), .POReqRdy_M1(POReqRdy_M1), .PIReqCntl_M1(PIReqCntl_M1),
      .PIReqAdrs_M1(PIReqAdrs_M1), .PIReqData_M1(PIReqData_M1), .PIReqDataBE_M1(PIReqDataBE_M1),
      .PIReqId_M1(PIReqId_M1), .PIReqPriority_M1(PIReqPriority_M1), .PORespValid_M1(PORespValid_M1),
      .PIRespRdy_M1(PIRespRdy_M1), .PORespCntl_M1(PORespCntl_M1), .PORespData_M1(PORespData_M1),
      .PORespId_M1(PORespId_M1), .PORespPriority_M1(PORespPriority_M1),
      .PIReqValid_S(PIReqValid_S), .PIReqCntl_S(PIReqCntl_S), .PIReqAdrs_S(PIReqAdrs_S),
      .PIReqData_S(PIReqData_S), .PIReqDataBE_S(PIReqDataBE_S), .PIReqId_S(PIReqId_S),
      .PIReqPriority_S(PIReqPriority_S), .POReqRdy_S(POReqRdy_S),
      .PORespValid_S(PORespValid_S), .PORespCntl_S(PORespCntl_S), .PORespData_S(PORespData_S),
      .PORespId_S(PORespId_S), .PORespPriority_S(PORespPriority_S), .PIRespRdy_S(PIRespRdy_S)
   );

   task automatic idle_inputs();
      PIReqValid_M0 = 0; PIReqCntl_M0 = 0; PIReqAdrs_M0 = 0; PIReqData_M0 = 0;
      PIReqDataBE_M0 = 0; PIReqId_M0 = 0; PIReqPriority_M0 = 0; PIRespRdy_M0 = 0;
      PIReqValid_M1 = 0; PIReqCntl_M1 = 0; PIReqAdrs_M1 = 0; PIReqData_M1 = 0;
      PIReqDataBE_M1 = 0; PIReqId_M1 = 0; PIReqPriority_M1 = 0; PIRespRdy_M1 = 0;
      POReqRdy_S = 1; PORespValid_S = 0; PORespCntl_S = 0; PORespData_S = 0;
      PORespId_S = 0; PORespPriority_S = 0;
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic resp_clear(input logic [ID_W-1:0] id);
      PORespValid_S = 1; PORespCntl_S = 8'h01; PORespId_S = id;
      PIRespRdy_M0 = 1; PIRespRdy_M1 = 1;
      next_cycle();
      PORespValid_S = 0; PIRespRdy_M0 = 0; PIRespRdy_M1 = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      RESETN = 0;
      PIReqValid_M0 = 1; PIReqValid_M1 = 1; PIReqCntl_M0 = 1; PIReqCntl_M1 = 1;
      PORespValid_S = 1; PIRespRdy_M0 = 1; PIRespRdy_M1 = 1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      vectors++; if (PIReqValid_S !== 1'b0) begin miscompares++; $display("FAIL rst_reqvalid_s got %b exp 0", PIReqValid_S); end
      vectors++; if (POReqRdy_M0 !== 1'b0) begin miscompares++; $display("FAIL rst_rdy_m0 got %b exp 0", POReqRdy_M0); end
      vectors++; if (POReqRdy_M1 !== 1'b0) begin miscompares++; $display("FAIL rst_rdy_m1 got %b exp 0", POReqRdy_M1); end
      vectors++; if (PORespValid_M0 !== 1'b0) begin miscompares++; $display("FAIL rst_respvalid_m0 got %b exp 0", PORespValid_M0); end
      vectors++; if (PORespValid_M1 !== 1'b0) begin miscompares++; $display("FAIL rst_respvalid_m1 got %b exp 0", PORespValid_M1); end
      vectors++; if (PIRespRdy_S !== 1'b0) begin miscompares++; $display("FAIL rst_resprdy_s got %b exp 0", PIRespRdy_S); end
      next_cycle();
      idle_inputs();
      RESETN = 1;
   endtask

   task automatic test_tie();
      PIReqValid_M0 = 1; PIReqCntl_M0 = 8'h01; PIReqAdrs_M0 = 32'h1000_0300; PIReqId_M0 = 3; PIReqDataBE_M0 = 4'h3;
      PIReqValid_M1 = 1; PIReqCntl_M1 = 8'h01; PIReqAdrs_M1 = 32'h1000_0500; PIReqId_M1 = 5; PIReqDataBE_M1 = 4'hC;
      @(negedge CLK);
      vectors++; if (POReqRdy_M0 !== 1'b1) begin miscompares++; $display("FAIL tie_c0_rdy_m0 got %b exp 1", POReqRdy_M0); end
      vectors++; if (POReqRdy_M1 !== 1'b0) begin miscompares++; $display("FAIL tie_c0_rdy_m1 got %b exp 0", POReqRdy_M1); end
      vectors++; if (PIReqValid_S !== 1'b1) begin miscompares++; $display("FAIL tie_c0_valid_s got %b exp 1", PIReqValid_S); end
      vectors++; if (PIReqAdrs_S !== 32'h1000_0300) begin miscompares++; $display("FAIL tie_c0_adrs got %h exp 10000300", PIReqAdrs_S); end
      vectors++; if (PIReqDataBE_S !== 4'h3) begin miscompares++; $display("FAIL tie_c0_be got %h exp 3", PIReqDataBE_S); end
      next_cycle();
      PIReqValid_M0 = 0;
      @(negedge CLK);
      vectors++; if (POReqRdy_M1 !== 1'b1) begin miscompares++; $display("FAIL tie_c1_rdy_m1 got %b exp 1", POReqRdy_M1); end
      vectors++; if (POReqRdy_M0 !== 1'b0) begin miscompares++; $display("FAIL tie_c1_rdy_m0 got %b exp 0", POReqRdy_M0); end
      vectors++; if (PIReqId_S !== 6'd5) begin miscompares++; $display("FAIL tie_c1_id got %0d exp 5", PIReqId_S); end
      next_cycle();
      PIReqValid_M1 = 0;
      PORespValid_S = 1; PORespCntl_S = 8'h01; PORespId_S = 5; PORespData_S = 32'hD5D5_0005; PORespPriority_S = 2;
      PIRespRdy_M0 = 0; PIRespRdy_M1 = 1;
      @(negedge CLK);
      vectors++; if (PORespValid_M1 !== 1'b1) begin miscompares++; $display("FAIL tie_r5_valid_m1 got %b exp 1", PORespValid_M1); end
      vectors++; if (PORespValid_M0 !== 1'b0) begin miscompares++; $display("FAIL tie_r5_valid_m0 got %b exp 0", PORespValid_M0); end
      vectors++; if (PIRespRdy_S !== 1'b1) begin miscompares++; $display("FAIL tie_r5_rdy_s got %b exp 1", PIRespRdy_S); end
      vectors++; if (PORespData_M1 !== 32'hD5D5_0005) begin miscompares++; $display("FAIL tie_r5_data got %h exp d5d50005", PORespData_M1); end
      vectors++; if (PORespPriority_M1 !== 2'd2) begin miscompares++; $display("FAIL tie_r5_prio got %0d exp 2", PORespPriority_M1); end
      vectors++; if (PORespId_M0 !== 6'd5) begin miscompares++; $display("FAIL tie_r5_id_copy_m0 got %0d exp 5", PORespId_M0); end
      next_cycle();
      PORespId_S = 3; PORespData_S = 32'hD3D3_0003; PIRespRdy_M0 = 1; PIRespRdy_M1 = 0;
      @(negedge CLK);
      vectors++; if (PORespValid_M0 !== 1'b1) begin miscompares++; $display("FAIL tie_r3_valid_m0 got %b exp 1", PORespValid_M0); end
      vectors++; if (PORespValid_M1 !== 1'b0) begin miscompares++; $display("FAIL tie_r3_valid_m1 got %b exp 0", PORespValid_M1); end
      vectors++; if (PIRespRdy_S !== 1'b1) begin miscompares++; $display("FAIL tie_r3_rdy_s got %b exp 1", PIRespRdy_S); end
      vectors++; if (PORespData_M0 !== 32'hD3D3_0003) begin miscompares++; $display("FAIL tie_r3_data got %h exp d3d30003", PORespData_M0); end
      vectors++; if (PORespCntl_M0 !== 8'h01) begin miscompares++; $display("FAIL tie_r3_cntl got %h exp 01", PORespCntl_M0); end
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_lock();
      for (int i = 0; i < 4; i++) begin
         PIReqValid_M1 = 1; PIReqId_M1 = 10; PIReqCntl_M1 = (i == 3) ? 8'h01 : 8'h00;
         PIReqAdrs_M1 = 32'h2000_0000 + 32'(4 * i); PIReqData_M1 = 32'hB000_0000 + 32'(i);
         if (i >= 2) begin
            PIReqValid_M0 = 1; PIReqId_M0 = 11; PIReqCntl_M0 = 8'h01; PIReqAdrs_M0 = 32'h3000_0000;
         end
         @(negedge CLK);
         vectors++; if (POReqRdy_M1 !== 1'b1) begin miscompares++; $display("FAIL lock_b%0d_rdy_m1 got %b exp 1", i, POReqRdy_M1); end
         vectors++; if (POReqRdy_M0 !== 1'b0) begin miscompares++; $display("FAIL lock_b%0d_rdy_m0 got %b exp 0", i, POReqRdy_M0); end
         vectors++; if (PIReqData_S !== 32'hB000_0000 + 32'(i)) begin miscompares++; $display("FAIL lock_b%0d_data got %h exp %h", i, PIReqData_S, 32'hB000_0000 + 32'(i)); end
         next_cycle();
      end
      PIReqValid_M1 = 0;
      @(negedge CLK);
      vectors++; if (POReqRdy_M0 !== 1'b1) begin miscompares++; $display("FAIL lock_after_rdy_m0 got %b exp 1", POReqRdy_M0); end
      vectors++; if (PIReqId_S !== 6'd11) begin miscompares++; $display("FAIL lock_after_id got %0d exp 11", PIReqId_S); end
      next_cycle();
      idle_inputs();
      resp_clear(10);
      resp_clear(11);
   endtask

   task automatic test_id_block();
      PIReqValid_M0 = 1; PIReqId_M0 = 7; PIReqCntl_M0 = 8'h01; PIReqAdrs_M0 = 32'h4000_0007;
      @(negedge CLK);
      vectors++; if (POReqRdy_M0 !== 1'b1) begin miscompares++; $display("FAIL idb_rdy_m0 got %b exp 1", POReqRdy_M0); end
      next_cycle();
      PIReqValid_M0 = 0;
      PIReqValid_M1 = 1; PIReqId_M1 = 7; PIReqCntl_M1 = 8'h01; PIReqAdrs_M1 = 32'h5000_0007;
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         vectors++; if (POReqRdy_M1 !== 1'b0) begin miscompares++; $display("FAIL idb_wait%0d_rdy_m1 got %b exp 0", c, POReqRdy_M1); end
         vectors++; if (PIReqValid_S !== 1'b0) begin miscompares++; $display("FAIL idb_wait%0d_valid_s got %b exp 0", c, PIReqValid_S); end
         next_cycle();
      end
      PORespValid_S = 1; PORespCntl_S = 8'h01; PORespId_S = 7; PIRespRdy_M0 = 1; PIRespRdy_M1 = 0;
      @(negedge CLK);
      vectors++; if (POReqRdy_M1 !== 1'b0) begin miscompares++; $display("FAIL idb_resp_rdy_m1 got %b exp 0", POReqRdy_M1); end
      vectors++; if (PORespValid_M0 !== 1'b1) begin miscompares++; $display("FAIL idb_resp_valid_m0 got %b exp 1", PORespValid_M0); end
      next_cycle();
      PORespValid_S = 0; PIRespRdy_M0 = 0;
      @(negedge CLK);
      vectors++; if (POReqRdy_M1 !== 1'b1) begin miscompares++; $display("FAIL idb_grant_rdy_m1 got %b exp 1", POReqRdy_M1); end
      vectors++; if (PIReqAdrs_S !== 32'h5000_0007) begin miscompares++; $display("FAIL idb_grant_adrs got %h exp 50000007", PIReqAdrs_S); end
      next_cycle();
      PIReqValid_M1 = 0;
      PORespValid_S = 1; PORespCntl_S = 8'h01; PORespId_S = 7; PIRespRdy_M1 = 1;
      @(negedge CLK);
      vectors++; if (PORespValid_M1 !== 1'b1) begin miscompares++; $display("FAIL idb_r2_valid_m1 got %b exp 1", PORespValid_M1); end
      vectors++; if (PORespValid_M0 !== 1'b0) begin miscompares++; $display("FAIL idb_r2_valid_m0 got %b exp 0", PORespValid_M0); end
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_resp_burst();
      logic [5:0] rdy_pat;
      int beat;
      rdy_pat = 6'b101101;
      beat = 0;
      PIReqValid_M1 = 1; PIReqId_M1 = 20; PIReqCntl_M1 = 8'h01; PIReqAdrs_M1 = 32'h7000_0000;
      next_cycle();
      PIReqValid_M1 = 0;
      PIRespRdy_M0 = 1;
      for (int c = 0; c < 6; c++) begin
         PORespValid_S = 1; PORespId_S = 20; PORespCntl_S = (beat == 3) ? 8'h01 : 8'h00;
         PORespData_S = 32'hCAFE_0000 + 32'(beat); PIRespRdy_M1 = rdy_pat[c];
         @(negedge CLK);
         vectors++; if (PIRespRdy_S !== rdy_pat[c]) begin miscompares++; $display("FAIL rb_c%0d_rdy_s got %b exp %b", c, PIRespRdy_S, rdy_pat[c]); end
         vectors++; if (PORespValid_M1 !== 1'b1) begin miscompares++; $display("FAIL rb_c%0d_valid_m1 got %b exp 1", c, PORespValid_M1); end
         vectors++; if (PORespValid_M0 !== 1'b0) begin miscompares++; $display("FAIL rb_c%0d_valid_m0 got %b exp 0", c, PORespValid_M0); end
         vectors++; if (PORespData_M1 !== 32'hCAFE_0000 + 32'(beat)) begin miscompares++; $display("FAIL rb_c%0d_data got %h exp %h", c, PORespData_M1, 32'hCAFE_0000 + 32'(beat)); end
         next_cycle();
         if (rdy_pat[c]) beat++;
      end
      idle_inputs();
      PIReqValid_M0 = 1; PIReqId_M0 = 20; PIReqCntl_M0 = 8'h01;
      @(negedge CLK);
      vectors++; if (POReqRdy_M0 !== 1'b1) begin miscompares++; $display("FAIL rb_reuse_rdy_m0 got %b exp 1", POReqRdy_M0); end
      next_cycle();
      idle_inputs();
      resp_clear(20);
   endtask

   task automatic test_reset_mid_burst();
      PIReqValid_M1 = 1; PIReqId_M1 = 40; PIReqCntl_M1 = 8'h01; PIReqAdrs_M1 = 32'h6000_0040;
      next_cycle();
      PIReqValid_M1 = 0;
      for (int i = 0; i < 2; i++) begin
         PIReqValid_M0 = 1; PIReqId_M0 = 30; PIReqCntl_M0 = 8'h00; PIReqAdrs_M0 = 32'h8000_0000 + 32'(4 * i);
         next_cycle();
      end
      PIReqAdrs_M0 = 32'h8000_0008;
      PIReqValid_M1 = 1; PIReqId_M1 = 31; PIReqCntl_M1 = 8'h01;
      PORespValid_S = 1; PORespCntl_S = 8'h01; PORespId_S = 40; PIRespRdy_M0 = 1; PIRespRdy_M1 = 1;
      #1;
      vectors++; if (POReqRdy_M0 !== 1'b1) begin miscompares++; $display("FAIL rmb_pre_rdy_m0 got %b exp 1", POReqRdy_M0); end
      vectors++; if (POReqRdy_M1 !== 1'b0) begin miscompares++; $display("FAIL rmb_pre_rdy_m1 got %b exp 0", POReqRdy_M1); end
      RESETN = 0;
      #1;
      vectors++; if (PIReqValid_S !== 1'b0) begin miscompares++; $display("FAIL rmb_valid_s got %b exp 0", PIReqValid_S); end
      vectors++; if (POReqRdy_M0 !== 1'b0) begin miscompares++; $display("FAIL rmb_rdy_m0 got %b exp 0", POReqRdy_M0); end
      vectors++; if (POReqRdy_M1 !== 1'b0) begin miscompares++; $display("FAIL rmb_rdy_m1 got %b exp 0", POReqRdy_M1); end
      vectors++; if (PORespValid_M1 !== 1'b0) begin miscompares++; $display("FAIL rmb_respvalid_m1 got %b exp 0", PORespValid_M1); end
      vectors++; if (PORespValid_M0 !== 1'b0) begin miscompares++; $display("FAIL rmb_respvalid_m0 got %b exp 0", PORespValid_M0); end
      vectors++; if (PIRespRdy_S !== 1'b0) begin miscompares++; $display("FAIL rmb_resprdy_s got %b exp 0", PIRespRdy_S); end
      next_cycle();
      idle_inputs();
      RESETN = 1;
      PIReqValid_M0 = 1; PIReqId_M0 = 30; PIReqCntl_M0 = 8'h01;
      PIReqValid_M1 = 1; PIReqId_M1 = 40; PIReqCntl_M1 = 8'h01;
      @(negedge CLK);
      vectors++; if (POReqRdy_M0 !== 1'b1) begin miscompares++; $display("FAIL rmb_tie_rdy_m0 got %b exp 1", POReqRdy_M0); end
      vectors++; if (POReqRdy_M1 !== 1'b0) begin miscompares++; $display("FAIL rmb_tie_rdy_m1 got %b exp 0", POReqRdy_M1); end
      next_cycle();
      PIReqValid_M0 = 0;
      @(negedge CLK);
      vectors++; if (POReqRdy_M1 !== 1'b1) begin miscompares++; $display("FAIL rmb_id40_rdy_m1 got %b exp 1", POReqRdy_M1); end
      vectors++; if (PIReqId_S !== 6'd40) begin miscompares++; $display("FAIL rmb_id40_id got %0d exp 40", PIReqId_S); end
      next_cycle();
      idle_inputs();
      resp_clear(30);
      resp_clear(40);
   endtask

   task automatic test_priority();
      logic exp_first;
`ifdef PEREGRINE_PIFARB_PRIORITY_EN
      exp_first = 1'b1;
`else
      exp_first = 1'b0;
`endif
      PIReqValid_M0 = 1; PIReqId_M0 = 50; PIReqCntl_M0 = 8'h01; PIReqPriority_M0 = 0;
      PIReqValid_M1 = 1; PIReqId_M1 = 51; PIReqCntl_M1 = 8'h01; PIReqPriority_M1 = 3;
      @(negedge CLK);
      vectors++; if (POReqRdy_M1 !== exp_first) begin miscompares++; $display("FAIL prio_first_rdy_m1 got %b exp %b", POReqRdy_M1, exp_first); end
      vectors++; if (POReqRdy_M0 !== !exp_first) begin miscompares++; $display("FAIL prio_first_rdy_m0 got %b exp %b", POReqRdy_M0, !exp_first); end
      vectors++; if (PIReqPriority_S !== (exp_first ? 2'd3 : 2'd0)) begin miscompares++; $display("FAIL prio_first_fwd got %0d exp %0d", PIReqPriority_S, exp_first ? 3 : 0); end
      next_cycle();
      if (exp_first) PIReqValid_M1 = 0; else PIReqValid_M0 = 0;
      @(negedge CLK);
      vectors++; if (POReqRdy_M1 !== !exp_first) begin miscompares++; $display("FAIL prio_second_rdy_m1 got %b exp %b", POReqRdy_M1, !exp_first); end
      next_cycle();
      idle_inputs();
      PIReqValid_M0 = 1; PIReqId_M0 = 52; PIReqCntl_M0 = 8'h01; PIReqPriority_M0 = 1;
      PIReqValid_M1 = 1; PIReqId_M1 = 53; PIReqCntl_M1 = 8'h01; PIReqPriority_M1 = 1;
      @(negedge CLK);
      vectors++; if (POReqRdy_M1 !== exp_first) begin miscompares++; $display("FAIL prio_equal_rdy_m1 got %b exp %b", POReqRdy_M1, exp_first); end
      vectors++; if (PIReqPriority_S !== 2'd1) begin miscompares++; $display("FAIL prio_equal_fwd got %0d exp 1", PIReqPriority_S); end
      next_cycle();
      idle_inputs();
      resp_clear(50);
      resp_clear(51);
      resp_clear(exp_first ? 6'd53 : 6'd52);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      RESETN = 0;
      idle_inputs();
      test_reset();
      test_tie();
      test_lock();
      test_id_block();
      test_resp_burst();
      test_reset_mid_burst();
      test_priority();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
